// File: rtl/mod_counter_core_if.sv
// Counter bus between the stimulus driver and the counter core.
//   load     : load request, sampled on the rising clock edge
//   data_in  : value to load
//   data_out : registered count value returned to the monitor
// Modports:
//   master : driver side (drives load/data_in, observes data_out)
//   slave  : counter side (consumes load/data_in, produces data_out)
interface mod_counter_core_if #(
    parameter int unsigned WIDTH = 4
) ();

    logic             load;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;

    modport master (
        output load,
        output data_in,
        input  data_out
    );

    modport slave (
        input  load,
        input  data_in,
        output data_out
    );

endinterface : mod_counter_core_if

// File: rtl/mod_counter_core.sv
// Loadable up/down modulo-(MAX_VAL+1) counter with clamped loads, a wrap
// pulse, a sticky wrap flag, a saturating wrap counter and a run indicator.
// Ports:
//   clock     : system clock, all state changes on the rising edge
//   rst       : asynchronous reset, active low
//   bus       : counter bus (load, data_in in; data_out out)
//   en        : count enable
//   up_dn     : count direction, 1 = up, 0 = down
//   tc        : one-cycle pulse in the cycle data_out shows the wrapped value
//   wrapped   : sticky wrap flag, cleared by load or reset
//   wrap_cnt  : saturating number of wraps since the last load or reset
//   load_err  : one-cycle pulse when a load value was clamped to MAX_VAL
//   running   : high while the controller is in RUN
// All outputs are registered; each reflects the inputs sampled on the
// preceding rising edge.
module mod_counter_core #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned MAX_VAL    = 15,
    parameter int unsigned WRAP_CNT_W = 4
) (
    input  logic                  clock,
    input  logic                  rst,
    mod_counter_core_if.slave     bus,
    input  logic                  en,
    input  logic                  up_dn,
    output logic                  tc,
    output logic                  wrapped,
    output logic [WRAP_CNT_W-1:0] wrap_cnt,
    output logic                  load_err,
    output logic                  running
);

    localparam logic [WIDTH-1:0]      MAX_V    = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0]      ZERO_V   = '0;
    localparam logic [WIDTH-1:0]      ONE_V    = WIDTH'(1);
    localparam logic [WRAP_CNT_W-1:0] WCNT_SAT = '1;
    localparam logic [WRAP_CNT_W-1:0] WCNT_ONE = WRAP_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e                  state_q;
    state_e                  state_d;

    logic [WIDTH-1:0]        count_q;
    logic [WIDTH-1:0]        count_d;
    logic                    tc_q;
    logic                    tc_d;
    logic                    wrapped_q;
    logic                    wrapped_d;
    logic [WRAP_CNT_W-1:0]   wrap_cnt_q;
    logic [WRAP_CNT_W-1:0]   wrap_cnt_d;
    logic                    load_err_q;
    logic                    load_err_d;
    logic                    running_q;
    logic                    running_d;

    // Decoded operation for this edge: load beats count, count beats hold.
    logic                    load_c;
    logic                    count_c;
    logic                    over_c;
    logic                    at_top_c;
    logic                    at_bottom_c;
    logic                    wrap_c;

    always_comb begin
        load_c      = bus.load;
        count_c     = en & ~bus.load;
        over_c      = (bus.data_in > MAX_V);
        at_top_c    = (count_q == MAX_V);
        at_bottom_c = (count_q == ZERO_V);
        // A wrap happens only on a counting edge at the end of the range
        // in the current direction.
        wrap_c      = count_c & (up_dn ? at_top_c : at_bottom_c);
    end

    // Controller state register.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Controller next state. IDLE is left on the first load or count and
    // is only re-entered through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load_c) begin
                    state_d = ST_HOLD;
                end else if (count_c) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!count_c) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (count_c) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next values for the count datapath and all status outputs.
    always_comb begin
        count_d    = count_q;
        tc_d       = 1'b0;
        wrapped_d  = wrapped_q;
        wrap_cnt_d = wrap_cnt_q;
        load_err_d = 1'b0;
        running_d  = (state_d == ST_RUN);

        if (load_c) begin
            if (over_c) begin
                count_d    = MAX_V;
                load_err_d = 1'b1;
            end else begin
                count_d    = bus.data_in;
            end
            wrapped_d  = 1'b0;
            wrap_cnt_d = '0;
        end else if (count_c) begin
            if (wrap_c) begin
                count_d   = up_dn ? ZERO_V : MAX_V;
                tc_d      = 1'b1;
                wrapped_d = 1'b1;
                if (wrap_cnt_q != WCNT_SAT) begin
                    wrap_cnt_d = wrap_cnt_q + WCNT_ONE;
                end
            end else if (up_dn) begin
                count_d = count_q + ONE_V;
            end else begin
                count_d = count_q - ONE_V;
            end
        end
    end

    // Datapath and status registers.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            count_q    <= '0;
            tc_q       <= 1'b0;
            wrapped_q  <= 1'b0;
            wrap_cnt_q <= '0;
            load_err_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            count_q    <= count_d;
            tc_q       <= tc_d;
            wrapped_q  <= wrapped_d;
            wrap_cnt_q <= wrap_cnt_d;
            load_err_q <= load_err_d;
            running_q  <= running_d;
        end
    end

    assign bus.data_out = count_q;
    assign tc           = tc_q;
    assign wrapped      = wrapped_q;
    assign wrap_cnt     = wrap_cnt_q;
    assign load_err     = load_err_q;
    assign running      = running_q;

    // Control inputs must be known whenever the block is out of reset.
    a_inputs_known: assert property (
        @(posedge clock) disable iff (!rst)
        !$isunknown({bus.load, en, up_dn})
    );

    // The count never leaves the modulus range.
    a_count_in_range: assert property (
        @(posedge clock) disable iff (!rst)
        count_q <= MAX_V
    );

    // A wrap pulse always coincides with a terminal value on data_out.
    a_tc_on_terminal: assert property (
        @(posedge clock) disable iff (!rst)
        tc_q |-> ((count_q == ZERO_V) || (count_q == MAX_V))
    );

endmodule : mod_counter_core
